msx_slot_master: RTL and testbench
==================================

Name: msx_slot_master

Overview:
- Bus initiator for the MSX cartridge slot: turns single-beat host requests into Z80-timed memory, IO and M1 cycles on the slot pins.
- Drives the same strobes a cartridge mapper decodes: MREQ, IORQ, RD, WR, M1, RFSH, EXSLTSL.
- Used as the host end of cartridge test rigs and dumper/programmer boards.
- One SLOTCLK cycle equals one Z80 T-state. All outputs are registered.

Parameters:
- M1_WAITS, 1: mandatory wait states inserted in M1 fetch (MSX engine default).
- IO_WAITS, 1: mandatory wait states in IO cycles (Z80 automatic TW).
- WAIT_TIMEOUT, 255: maximum consecutive WAIT-extended cycles before abort; 8-bit counter.

Ports:
- SLOTCLK  in  1  single clock; all state changes on its rising edge.
- RESET  in  1  asynchronous, active-high reset.
- REQ  in  1  host request; sampled only while BUSY=0.
- REQ_KIND  in  2  00 mem read, 01 mem write, 10 IO read, 11 IO write.
- REQ_M1  in  1  with KIND=00: opcode fetch plus refresh.
- REQ_ADDR  in  16  cycle address.
- REQ_WDATA  in  8  write data.
- BUSY  out  1  cycle in progress.
- ACK  out  1  one-cycle completion pulse.
- ERR  out  1  qualifies ACK: timeout abort.
- RDATA  out  8  read data; valid from the ACK cycle, held until the next read completes.
- A  out  16  slot address.
- D_OUT  out  8  write data to slot.
- D_OE  out  1  host drives D.
- D_IN  in  8  slot data.
- BDIR  out  1  buffer direction; 1 = slot drives D (read strobe active).
- MREQ, IORQ, RD, WR, M1, RFSH, EXSLTSL  out  1 each  active-low strobes.
- WAIT  in  1  active-low wait from slot.

Behaviour:
- Reset (asynchronous): all strobes 1; A=0, D_OUT=0, D_OE=0, BDIR=0, BUSY=0, ACK=0, ERR=0, RDATA=0, R=0.
- Reset mid-cycle: strobes release immediately. No ACK is issued and the request is lost.
- States: IDLE, T1, T2, TW, T3, T4 (refresh). Internal 7-bit R counter and wait/timeout counters.
- IDLE:
  - On REQ=1, capture the fields, set BUSY=1 and go to T1 next edge.
  - REQ while BUSY=1 is ignored.
- Memory read, REQ_M1=0:
  - T1: A valid; MREQ=0, RD=0, EXSLTSL=0, BDIR=1.
  - T2: then TW while WAIT=0, sampled at the end of T2/TW.
  - T3: D_IN sampled into RDATA at the edge ending T3. All strobes return to 1 on that edge, with ACK=1 for one cycle. Then IDLE.
  - Total 3 cycles with no wait.
- Memory write:
  - T1: A, D_OUT valid, D_OE=1, MREQ=0, EXSLTSL=0.
  - WR=0 from T2 through T3.
  - D_OE drops with the strobes at the end of T3. ACK as for read.
- IO read/write:
  - T1: A valid, no strobes.
  - IORQ=0 and RD/WR=0 from T2.
  - IO_WAITS forced TW cycles, then further TW while WAIT=0, then T3.
  - EXSLTSL stays 1.
  - For writes, D_OE=1 from T1 through T3.
- M1 fetch:
  - M1=0, MREQ=0, RD=0, EXSLTSL=0 from T1.
  - M1_WAITS forced TW cycles, then WAIT-extended.
  - D_IN is sampled at the edge ending T2/last TW.
  - T3: M1=RD=1; RFSH=0, MREQ=0, A={8'h00,1'b0,R}, EXSLTSL=1.
  - T4: MREQ=1, RFSH held 0. ACK at the end of T4.
  - R increments modulo 128 after every M1 (7F wraps to 00).
  - Total 4+M1_WAITS cycles with WAIT=1.
- WAIT sampling:
  - WAIT is only meaningful in T2/TW. In other states it is ignored.
  - Forced waits count first; WAIT is checked on the last forced/T2 cycle.
- Timeout:
  - When WAIT_TIMEOUT consecutive WAIT-extended TW cycles elapse, the cycle aborts on the next edge.
  - On abort: strobes release, RDATA is unchanged, ACK=1 and ERR=1 for one cycle.
  - An M1 cycle aborts without a refresh phase and without incrementing R.
- ACK and ERR are never high outside the single completion cycle.
- BUSY deasserts in the cycle after ACK. A new REQ is accepted no earlier than that.

Test Plan:
- Mem read 0x4000, WAIT=1, D_IN=0xA5:
  - MREQ/RD/EXSLTSL low for exactly 3 cycles.
  - ACK one cycle, RDATA=0xA5, ERR=0.
- Mem write 0x6000 data 0x03 with WAIT=0 for 2 cycles:
  - WR low 2+2 cycles, D_OUT=0x03 with D_OE=1 T1..T3.
  - ACK after 5 cycles total.
- IO write port 0x98 data 0x55, defaults:
  - IORQ/WR low from T2, one forced TW, EXSLTSL stays 1.
  - 4 cycles total.
- Two M1 fetches starting with R=0x7F:
  - First refresh shows A=0x007F; second shows A=0x0000.
  - RFSH low 2 cycles each; fetched data captured before refresh.
- WAIT held low, WAIT_TIMEOUT=4:
  - ACK with ERR=1 after 4 TW cycles; strobes released; RDATA unchanged.
- Assert RESET in TW of a read:
  - All strobes 1 and D_OE=0 immediately, BUSY=0, no ACK.
  - Next REQ completes normally.

Source files
------------

// File: rtl/msx_slot_master.sv
// msx_slot_master: host-side initiator that turns single-beat requests into
// Z80-timed memory, IO and M1/refresh cycles on an MSX cartridge slot.
module msx_slot_master #(
   parameter int unsigned M1_WAITS     = 1,
   parameter int unsigned IO_WAITS     = 1,
   parameter int unsigned WAIT_TIMEOUT = 255
) (
   input  logic        SLOTCLK,
   input  logic        RESET,
   input  logic        REQ,
   input  logic [1:0]  REQ_KIND,
   input  logic        REQ_M1,
   input  logic [15:0] REQ_ADDR,
   input  logic [7:0]  REQ_WDATA,
   output logic        BUSY,
   output logic        ACK,
   output logic        ERR,
   output logic [7:0]  RDATA,
   output logic [15:0] A,
   output logic [7:0]  D_OUT,
   output logic        D_OE,
   input  logic [7:0]  D_IN,
   output logic        BDIR,
   output logic        MREQ,
   output logic        IORQ,
   output logic        RD,
   output logic        WR,
   output logic        M1,
   output logic        RFSH,
   output logic        EXSLTSL,
   input  logic        WAIT
);

   typedef enum logic [2:0] {S_IDLE, S_T1, S_T2, S_TW, S_T3, S_T4} state_t;

   state_t      state, state_d;
   logic [1:0]  kind_q, kind_d;
   logic        m1_q, m1_d;
   logic [7:0]  frem, frem_d;
   logic [7:0]  wcnt, wcnt_d;
   logic [6:0]  r_q;
   logic [7:0]  forced;
   logic        accept, done, abort;
   logic        mreq_d, iorq_d, rd_d, wr_d, m1n_d, rfsh_d, exsl_d;
   logic        doe_d, bdir_d, busy_d, ack_d, err_d;

   assign accept = (state == S_IDLE) && !BUSY && REQ;
   assign kind_d = accept ? REQ_KIND : kind_q;
   assign m1_d   = accept ? (REQ_M1 && (REQ_KIND == 2'b00)) : m1_q;
   assign forced = m1_q ? 8'(M1_WAITS) : (kind_q[1] ? 8'(IO_WAITS) : '0);

   // State, datapath and registered outputs
   always_ff @(posedge SLOTCLK or posedge RESET) begin
      if (RESET) begin
         state   <= S_IDLE;
         kind_q  <= '0;
         m1_q    <= 1'b0;
         frem    <= '0;
         wcnt    <= '0;
         r_q     <= '0;
         BUSY    <= 1'b0;
         ACK     <= 1'b0;
         ERR     <= 1'b0;
         RDATA   <= '0;
         A       <= '0;
         D_OUT   <= '0;
         D_OE    <= 1'b0;
         BDIR    <= 1'b0;
         MREQ    <= 1'b1;
         IORQ    <= 1'b1;
         RD      <= 1'b1;
         WR      <= 1'b1;
         M1      <= 1'b1;
         RFSH    <= 1'b1;
         EXSLTSL <= 1'b1;
      end else begin
         state   <= state_d;
         kind_q  <= kind_d;
         m1_q    <= m1_d;
         frem    <= frem_d;
         wcnt    <= wcnt_d;
         BUSY    <= busy_d;
         ACK     <= ack_d;
         ERR     <= err_d;
         D_OE    <= doe_d;
         BDIR    <= bdir_d;
         MREQ    <= mreq_d;
         IORQ    <= iorq_d;
         RD      <= rd_d;
         WR      <= wr_d;
         M1      <= m1n_d;
         RFSH    <= rfsh_d;
         EXSLTSL <= exsl_d;
         if (accept) begin
            A     <= REQ_ADDR;
            D_OUT <= REQ_WDATA;
         end
         // Opcode is latched as the fetch leaves T2/TW, before the bus turns to refresh
         if (m1_q && (state_d == S_T3) && (state != S_T3)) begin
            A     <= {8'h00, 1'b0, r_q};
            RDATA <= D_IN;
         end
         if ((state == S_T3) && !m1_q && !kind_q[0])
            RDATA <= D_IN;
         if (state == S_T4)
            r_q <= r_q + 7'd1;
      end
   end

   // Next state: forced waits run down first, then WAIT extends with a timeout
   always_comb begin
      state_d = state;
      frem_d  = frem;
      wcnt_d  = wcnt;
      done    = 1'b0;
      abort   = 1'b0;
      case (state)
         S_IDLE: begin
            if (accept) begin
               state_d = S_T1;
               frem_d  = '0;
               wcnt_d  = '0;
            end
         end
         S_T1: state_d = S_T2;
         S_T2, S_TW: begin
            if ((state == S_T2) && (forced != '0)) begin
               state_d = S_TW;
               frem_d  = forced - 8'd1;
            end else if ((state == S_TW) && (frem != '0)) begin
               frem_d = frem - 8'd1;
            end else if (!WAIT) begin
               if (wcnt >= 8'(WAIT_TIMEOUT)) begin
                  state_d = S_IDLE;
                  abort   = 1'b1;
               end else begin
                  state_d = S_TW;
                  wcnt_d  = wcnt + 8'd1;
               end
            end else begin
               state_d = S_T3;
            end
         end
         S_T3: begin
            if (m1_q) begin
               state_d = S_T4;
            end else begin
               state_d = S_IDLE;
               done    = 1'b1;
            end
         end
         S_T4: begin
            state_d = S_IDLE;
            done    = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Output values for the cycle being entered
   always_comb begin
      mreq_d = 1'b1;
      iorq_d = 1'b1;
      rd_d   = 1'b1;
      wr_d   = 1'b1;
      m1n_d  = 1'b1;
      rfsh_d = 1'b1;
      exsl_d = 1'b1;
      doe_d  = 1'b0;
      bdir_d = 1'b0;
      ack_d  = done || abort;
      err_d  = abort;
      busy_d = (state_d != S_IDLE) || ack_d;
      case (state_d)
         S_T1, S_T2, S_TW, S_T3: begin
            if ((state_d == S_T3) && m1_d) begin
               mreq_d = 1'b0;
               rfsh_d = 1'b0;
            end else begin
               if (kind_d[1]) begin
                  if (state_d != S_T1) begin
                     iorq_d = 1'b0;
                     rd_d   = kind_d[0];
                     wr_d   = !kind_d[0];
                  end
               end else begin
                  mreq_d = 1'b0;
                  exsl_d = 1'b0;
                  m1n_d  = !m1_d;
                  rd_d   = kind_d[0];
                  wr_d   = !kind_d[0] || (state_d == S_T1);
               end
               doe_d  = kind_d[0];
               bdir_d = !rd_d;
            end
         end
         S_T4: rfsh_d = 1'b0;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_msx_slot_master.sv
// tb_msx_slot_master: scoreboard bench for msx_slot_master covering memory, IO,
// M1/refresh, WAIT timeout and mid-cycle reset, with a shortened timeout.
`timescale 1ns/1ps
module tb_msx_slot_master;
   localparam int unsigned M1_W = 1;
   localparam int unsigned IO_W = 1;
   localparam int unsigned TMO  = 4;

   typedef struct { int len, mreq, iorq, rd, wr, m1, rfsh, exsl, doe, bdir; } cnt_t;
   typedef struct { logic err; logic [7:0] rdata; } exp_t;

   logic        SLOTCLK = 1'b0;
   logic        RESET, REQ, REQ_M1, WAIT;
   logic [1:0]  REQ_KIND;
   logic [15:0] REQ_ADDR, A;
   logic [7:0]  REQ_WDATA, D_IN, RDATA, D_OUT;
   logic        BUSY, ACK, ERR, D_OE, BDIR;
   logic        MREQ, IORQ, RD, WR, M1, RFSH, EXSLTSL;

   int          n_cmp = 0;
   int          n_bad = 0;
   exp_t        sb[$];
   logic [7:0]  last_rdata = 8'h00;
   logic [6:0]  r_model = 7'h00;

   msx_slot_master #(.M1_WAITS(M1_W), .IO_WAITS(IO_W), .WAIT_TIMEOUT(TMO)) dut (
      .SLOTCLK(SLOTCLK), .RESET(RESET), .REQ(REQ), .REQ_KIND(REQ_KIND),
      .REQ_M1(REQ_M1), .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
      .BUSY(BUSY), .ACK(ACK), .ERR(ERR), .RDATA(RDATA), .A(A), .D_OUT(D_OUT),
      .D_OE(D_OE), .D_IN(D_IN), .BDIR(BDIR), .MREQ(MREQ), .IORQ(IORQ), .RD(RD),
      .WR(WR), .M1(M1), .RFSH(RFSH), .EXSLTSL(EXSLTSL), .WAIT(WAIT)
   );

   always #5 SLOTCLK = ~SLOTCLK;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic cnt_t cnt(input int len, mreq, iorq, rd, wr, m1, rfsh, exsl, doe, bdir);
      cnt_t c;
      c = '{len, mreq, iorq, rd, wr, m1, rfsh, exsl, doe, bdir};
      return c;
   endfunction

   // Completion side of the scoreboard
   always @(negedge SLOTCLK) begin : sb_check
      exp_t e;
      if (!RESET) begin
         if (ACK) begin
            if (sb.size() == 0) begin
               check_eq("ack_unexpected", 32'(ACK), 32'd0);
            end else begin
               e = sb.pop_front();
               check_eq("ack_err", 32'(ERR), 32'(e.err));
               check_eq("rdata", 32'(RDATA), 32'(e.rdata));
            end
         end else begin
            check_eq("err_without_ack", 32'(ERR), 32'd0);
         end
      end
   end

   task automatic run_txn(input string tag, input logic [1:0] kind, input logic m1,
                          input logic [15:0] addr, input logic [7:0] wdata, input logic [7:0] din,
                          input int unsigned nwait, input logic exp_err, input cnt_t exp);
      cnt_t        got;
      exp_t        e;
      int unsigned forced, chk, t3;
      bit          acked;
      got    = '{default: 0};
      acked  = 1'b0;
      forced = m1 ? M1_W : (kind[1] ? IO_W : 0);
      chk    = 2 + forced;
      t3     = chk + nwait + 1;
      e.err   = exp_err;
      e.rdata = (!kind[0] && !exp_err) ? din : last_rdata;
      last_rdata = e.rdata;
      sb.push_back(e);
      REQ = 1'b1; REQ_KIND = kind; REQ_M1 = m1; REQ_ADDR = addr; REQ_WDATA = wdata;
      D_IN = din; WAIT = 1'b1;
      for (int unsigned c = 1; c <= 300 && !acked; c++) begin
         @(negedge SLOTCLK);
         if (ACK) begin
            acked   = 1'b1;
            got.len = int'(c) - 1;
            check_eq({tag, "_ack_busy"}, 32'(BUSY), 32'd1);
            check_eq({tag, "_released"},
                     32'({D_OE, BDIR, MREQ, IORQ, RD, WR, M1, RFSH, EXSLTSL}), 32'h07F);
         end else begin
            got.mreq += MREQ ? 0 : 1;
            got.iorq += IORQ ? 0 : 1;
            got.rd   += RD ? 0 : 1;
            got.wr   += WR ? 0 : 1;
            got.m1   += M1 ? 0 : 1;
            got.rfsh += RFSH ? 0 : 1;
            got.exsl += EXSLTSL ? 0 : 1;
            got.doe  += D_OE ? 1 : 0;
            got.bdir += BDIR ? 1 : 0;
            if (c == 1) begin
               check_eq({tag, "_addr"}, 32'(A), 32'(addr));
               if (kind[0]) check_eq({tag, "_dout"}, 32'(D_OUT), 32'(wdata));
            end
            if (m1 && !exp_err && c == t3)
               check_eq({tag, "_rfsh_addr"}, 32'(A), 32'({9'd0, r_model}));
         end
         WAIT = (c >= chk && c < chk + nwait) ? 1'b0 : 1'b1;
         if (m1 && c >= t3) D_IN = ~din;
      end
      check_eq({tag, "_ack_seen"}, 32'(acked), 32'd1);
      check_eq({tag, "_len"},  32'(got.len),  32'(exp.len));
      check_eq({tag, "_mreq"}, 32'(got.mreq), 32'(exp.mreq));
      check_eq({tag, "_iorq"}, 32'(got.iorq), 32'(exp.iorq));
      check_eq({tag, "_rd"},   32'(got.rd),   32'(exp.rd));
      check_eq({tag, "_wr"},   32'(got.wr),   32'(exp.wr));
      check_eq({tag, "_m1"},   32'(got.m1),   32'(exp.m1));
      check_eq({tag, "_rfsh"}, 32'(got.rfsh), 32'(exp.rfsh));
      check_eq({tag, "_exsl"}, 32'(got.exsl), 32'(exp.exsl));
      check_eq({tag, "_doe"},  32'(got.doe),  32'(exp.doe));
      check_eq({tag, "_bdir"}, 32'(got.bdir), 32'(exp.bdir));
      // REQ stayed high through the ACK cycle; it must not have started a new cycle
      @(negedge SLOTCLK);
      check_eq({tag, "_idle"}, 32'({BUSY, ACK}), 32'd0);
      REQ  = 1'b0;
      WAIT = 1'b1;
      if (m1 && !exp_err) r_model = r_model + 7'd1;
   endtask

   initial begin
      RESET = 1'b0; REQ = 1'b0; REQ_KIND = 2'b00; REQ_M1 = 1'b0; REQ_ADDR = '0;
      REQ_WDATA = '0; D_IN = '0; WAIT = 1'b1;
      #1 RESET = 1'b1;
      #2;
      check_eq("rst_strobes", 32'({D_OE, BDIR, MREQ, IORQ, RD, WR, M1, RFSH, EXSLTSL}), 32'h07F);
      check_eq("rst_addr", 32'(A), 32'd0);
      check_eq("rst_dout", 32'(D_OUT), 32'd0);
      check_eq("rst_rdata", 32'(RDATA), 32'd0);
      check_eq("rst_flags", 32'({BUSY, ACK, ERR}), 32'd0);
      @(negedge SLOTCLK);
      RESET = 1'b0;
      @(negedge SLOTCLK);

      run_txn("mem_rd", 2'b00, 1'b0, 16'h4000, 8'h00, 8'hA5, 0, 1'b0, cnt(3,3,0,3,0,0,0,3,0,3));
      run_txn("mem_wr", 2'b01, 1'b0, 16'h6000, 8'h03, 8'h00, 2, 1'b0, cnt(5,5,0,0,4,0,0,5,5,0));
      run_txn("io_wr",  2'b11, 1'b0, 16'h0098, 8'h55, 8'h00, 0, 1'b0, cnt(4,0,3,0,3,0,0,0,4,0));
      run_txn("io_rd",  2'b10, 1'b0, 16'h0099, 8'h00, 8'h3C, 1, 1'b0, cnt(5,0,4,4,0,0,0,0,0,4));
      run_txn("rd_tmo", 2'b00, 1'b0, 16'h4002, 8'h00, 8'h11, 200, 1'b1, cnt(6,6,0,6,0,0,0,6,0,6));

      // Reset asserted while a read sits in TW
      REQ = 1'b1; REQ_KIND = 2'b00; REQ_M1 = 1'b0; REQ_ADDR = 16'h4000; D_IN = 8'h77; WAIT = 1'b0;
      @(negedge SLOTCLK);
      @(negedge SLOTCLK);
      REQ = 1'b0;
      repeat (3) @(negedge SLOTCLK);
      check_eq("rst_mid_pre_mreq", 32'(MREQ), 32'd0);
      #2 RESET = 1'b1;
      #1;
      check_eq("rst_mid_strobes", 32'({D_OE, BDIR, MREQ, IORQ, RD, WR, M1, RFSH, EXSLTSL}), 32'h07F);
      check_eq("rst_mid_flags", 32'({BUSY, ACK, ERR}), 32'd0);
      @(negedge SLOTCLK);
      RESET = 1'b0;
      WAIT = 1'b1;
      last_rdata = 8'h00;
      r_model = 7'h00;
      check_eq("rst_mid_rdata", 32'(RDATA), 32'd0);
      repeat (3) @(negedge SLOTCLK);
      run_txn("rd_after_rst", 2'b00, 1'b0, 16'h4001, 8'h00, 8'h5A, 0, 1'b0, cnt(3,3,0,3,0,0,0,3,0,3));

      // M1 fetches walk R through 7F and its wrap; one aborted fetch must leave R alone
      for (int i = 0; i < 129; i++) begin
         if (i == 10)
            run_txn("m1_tmo", 2'b00, 1'b1, 16'h8000, 8'h00, 8'hEE, 200, 1'b1, cnt(7,7,0,7,0,7,0,7,0,7));
         run_txn("m1", 2'b00, 1'b1, 16'h0100 + 16'(i), 8'h00, 8'(i) ^ 8'h5A, 0, 1'b0,
                 cnt(5,4,0,3,0,3,2,3,0,3));
      end

      repeat (2) @(negedge SLOTCLK);
      check_eq("sb_drained", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
